// File: rtl/adder_result_accum.sv
// rtl/adder_result_accum.sv - accumulates bursts of adder results into a wide total
// Samples are {carry, sum}; a burst closes on COUNT samples or an early flush.
module adder_result_accum #(
  parameter int DATA_W = 8,
  parameter int COUNT  = 4,
  localparam int ACC_W = DATA_W + 1 + $clog2(COUNT),
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sum,
  input  logic              in_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_total,
  output logic [CNT_W-1:0]  out_count
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ACC_W-1:0]   total_q;
  logic [CNT_W-1:0]   count_q;
  logic               out_valid_q;
  logic               in_ready_q;

  logic               hs;
  logic               emit;
  logic [ACC_W-1:0]   value;
  logic [ACC_W-1:0]   sum_d;
  logic [CNT_W-1:0]   cnt_d;

  assign hs    = in_valid & in_ready_q;
  assign value = {{(ACC_W-DATA_W-1){1'b0}}, in_carry, in_sum};
  assign sum_d = hs ? acc_q + value : acc_q;
  assign cnt_d = cnt_q + CNT_W'(hs);

  // A flush only closes a burst that actually holds at least one sample.
  assign emit  = (hs && (cnt_q == CNT_W'(COUNT - 1))) ||
                 (flush && (hs || (cnt_q != '0)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      total_q     <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else if (clear) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        ACCUM: begin
          if (emit) begin
            total_q     <= sum_d;
            count_q     <= cnt_d;
            acc_q       <= '0;
            cnt_q       <= '0;
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end else if (hs) begin
            acc_q <= sum_d;
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= ACCUM;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ACCUM;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_total = total_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_adder_result_accum.sv
// tb/tb_adder_result_accum.sv - scoreboard bench for adder_result_accum
module tb_adder_result_accum;

  localparam int DATA_W = 8;
  localparam int COUNT  = 4;
  localparam int ACC_W  = DATA_W + 1 + $clog2(COUNT);
  localparam int CNT_W  = $clog2(COUNT + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              clear = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_sum = '0;
  logic              in_carry = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [ACC_W-1:0]  out_total;
  logic [CNT_W-1:0]  out_count;

  int checks = 0;
  int errors = 0;

  logic [ACC_W-1:0] exp_total[$];
  logic [CNT_W-1:0] exp_count[$];

  adder_result_accum #(.DATA_W(DATA_W), .COUNT(COUNT)) dut (
    .clk(clk), .rst(rst), .clear(clear), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_carry(in_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_total(out_total), .out_count(out_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_total.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output total=%0d count=%0d", out_total, out_count);
      end else begin
        logic [ACC_W-1:0] et;
        logic [CNT_W-1:0] ec;
        et = exp_total.pop_front();
        ec = exp_count.pop_front();
        if (out_total !== et || out_count !== ec) begin
          errors++;
          $display("FAIL output total=%0d count=%0d expected total=%0d count=%0d",
                   out_total, out_count, et, ec);
        end
      end
    end
  end

  task automatic push_exp(input int t, input int c);
    exp_total.push_back(ACC_W'(t));
    exp_count.push_back(CNT_W'(c));
  endtask

  task automatic send(input logic c, input logic [DATA_W-1:0] s);
    int n = 0;
    in_valid = 1'b1;
    in_carry = c;
    in_sum   = s;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #15;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b expected 0", out_valid); end
    checks++;
    if (out_total !== '0) begin errors++; $display("FAIL reset_out_total got=%0d expected 0", out_total); end
    checks++;
    if (out_count !== '0) begin errors++; $display("FAIL reset_out_count got=%0d expected 0", out_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b expected 1", in_ready); end
  endtask

  task automatic test_burst();
    out_ready = 1'b1;
    push_exp(546, 4);
    send(1'b0, 8'd10);
    send(1'b0, 8'd20);
    send(1'b1, 8'd5);
    send(1'b0, 8'd255);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL burst_latency out_valid=%0b expected 1", out_valid); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL burst_in_ready got=%0b expected 0", in_ready); end
    wait_drain();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL burst_one_cycle out_valid=%0b expected 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    push_exp(546, 4);
    send(1'b0, 8'd10);
    send(1'b0, 8'd20);
    send(1'b1, 8'd5);
    send(1'b0, 8'd255);
    in_valid = 1'b1;
    in_carry = 1'b0;
    in_sum   = 8'd3;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_total !== ACC_W'(546)) begin
        errors++;
        $display("FAIL backpressure_hold cycle=%0d in_ready=%0b out_valid=%0b total=%0d expected 0/1/546",
                 i, in_ready, out_valid, out_total);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_release in_ready=%0b out_valid=%0b expected 1/0", in_ready, out_valid);
    end
    push_exp(6, 4);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    send(1'b0, 8'd1);
    wait_drain();
  endtask

  task automatic test_max_value();
    out_ready = 1'b1;
    push_exp(2044, 4);
    for (int i = 0; i < 4; i++) send(1'b1, 8'd255);
    wait_drain();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    push_exp(7, 2);
    send(1'b0, 8'd3);
    send(1'b0, 8'd4);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_partial out_valid=%0b expected 1", out_valid); end
    wait_drain();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty out_valid=%0b expected 0", out_valid); end
    push_exp(10, 2);
    send(1'b0, 8'd1);
    in_valid = 1'b1;
    in_carry = 1'b0;
    in_sum   = 8'd9;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_same_cycle out_valid=%0b expected 1", out_valid); end
    wait_drain();
  endtask

  task automatic test_clear();
    out_ready = 1'b1;
    send(1'b0, 8'd100);
    send(1'b0, 8'd50);
    in_valid = 1'b1;
    in_carry = 1'b0;
    in_sum   = 8'd7;
    clear    = 1'b1;
    @(posedge clk);
    #1;
    clear    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_partial out_valid=%0b expected 0", out_valid); end
    push_exp(4, 4);
    for (int i = 0; i < 4; i++) send(1'b0, 8'd1);
    wait_drain();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'd20);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL clear_hold_setup out_valid=%0b expected 1", out_valid); end
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clear_hold out_valid=%0b in_ready=%0b expected 0/1", out_valid, in_ready);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_in_hold();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 8'd30);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_hold_setup out_valid=%0b expected 1", out_valid); end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_total !== '0 || out_count !== '0) begin
      errors++;
      $display("FAIL rst_async out_valid=%0b total=%0d count=%0d expected 0/0/0",
               out_valid, out_total, out_count);
    end
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    push_exp(8, 4);
    for (int i = 0; i < 4; i++) send(1'b0, 8'd2);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_max_value();
    test_flush();
    test_clear();
    test_reset_in_hold();
    repeat (2) @(posedge clk);
    checks++;
    if (exp_total.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left pending=%0d expected 0", exp_total.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_result_accum.md
Name: adder_result_accum

Overview:
- Downstream consumer of the adder stage.
- Takes each adder result (sum plus carry-out) over a valid/ready handshake and accumulates a fixed-size burst of results into a wider total.
- Presents the burst total with its sample count on a valid/ready output port.
- Feeds the result checker / output sink that follows the adder in the datapath.

Parameters:
- DATA_W, 8: width of adder sum input.
- COUNT, 4: results per burst; legal range COUNT >= 2.
- ACC_W, DATA_W+1+$clog2(COUNT): accumulator/total width, derived; never overridden.
- CNT_W, $clog2(COUNT+1): width of out_count, derived.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release.
- clear  in  1  synchronous abort of any partial burst or pending output.
- flush  in  1  synchronous request to emit the partial total early.
- in_valid  in  1  adder result valid.
- in_ready  out  1  block accepts result.
- in_sum  in  DATA_W  adder sum.
- in_carry  in  1  adder carry-out.
- out_valid  out  1  total valid.
- out_ready  in  1  downstream accepts total.
- out_total  out  ACC_W  accumulated total.
- out_count  out  CNT_W  number of results in out_total (1..COUNT).

Behaviour:
- Sample value = {in_carry, in_sum}, zero-extended to ACC_W. Max total COUNT*(2^(DATA_W+1)-1) fits ACC_W, so no overflow is possible.
- Reset (rst=0, any time, including mid-burst or mid-HOLD):
  - state=ACCUM, acc=0, cnt=0.
  - out_valid=0, out_total=0, out_count=0, in_ready=1 (once rst=1).
- States: ACCUM, HOLD.
- ACCUM:
  - in_ready=1, out_valid=0.
  - Handshake (in_valid & in_ready): acc += value, cnt += 1.
  - If the handshake makes cnt==COUNT: next edge registers out_total=acc+value and out_count=COUNT, goes to HOLD, and clears acc/cnt.
  - flush=1 with cnt>0 or a same-cycle handshake: emit partial total, including that cycle's sample, then go to HOLD.
  - flush=1 with cnt==0 and no handshake: ignored.
- HOLD:
  - out_valid=1, in_ready=0.
  - out_total and out_count stay stable until out_ready=1.
  - On out_valid & out_ready: next edge goes to ACCUM with out_valid=0. No sample is accepted in the same cycle the output drains (in_ready is 0 in HOLD).
  - flush in HOLD: ignored.
- Latency: out_valid rises one cycle after the final accepted sample (or after the flush cycle).
- Maximum throughput: COUNT samples per COUNT+1 cycles when out_ready=1.
- clear (priority over handshake and flush, any state):
  - next edge: state=ACCUM, acc=0, cnt=0, out_valid=0.
  - A sample presented in the clear cycle is accepted at the port (in_ready=1 in ACCUM) but discarded.
  - A pending HOLD total is dropped.
- in_ready and out_valid are registered-state decodes: no combinational path from in_valid or out_ready.
- Inputs are not required to be stable while in_ready=0. The block samples only on handshake.

Test Plan (DATA_W=8, COUNT=4):
- Reset: hold rst=0 for 15 ns, release. Required: out_valid=0, out_total=0, in_ready=1. Assert rst=0 during HOLD: out_valid drops immediately (async).
- Burst: in_valid=1 with {carry,sum} = (0,10), (0,20), (1,5), (0,255), out_ready=1. Required: out_total=546, out_count=4, out_valid high for exactly one cycle, asserted the cycle after the 4th handshake.
- Backpressure: after burst, out_ready=0 for 10 cycles with in_valid=1. Required: in_ready=0, out_total=546 stable throughout. After out_ready=1, the next sample is accepted one cycle later.
- Max value: four samples of (1,255). Required: out_total=2044, no wrap (ACC_W=11).
- Flush: samples 3 and 4, then flush=1. Required: out_total=7, out_count=2. flush with no samples pending: no out_valid. flush with a same-cycle sample 9 after sample 1: out_total=10, out_count=2.
- Clear: two samples (100, 50), then clear=1 together with in_valid of 7. Then four samples of 1. Required: out_total=4, out_count=4. Clear during HOLD: pending total is never presented.
